// File: rtl/jtag_ocimem_sequencer.sv
// Sysclk-side executor for JTAG debug-module memory commands: turns the
// ocimem strobes into single Avalon-MM reads/writes and reports status back.
module jtag_ocimem_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic [ADDR_W-1:0] mon_address,
   output logic              mon_read,
   output logic              mon_write,
   output logic [31:0]       mon_writedata,
   input  logic [31:0]       mon_readdata,
   input  logic              mon_readdatavalid,
   input  logic              mon_waitrequest
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_REQ  = 2'd1;
   localparam logic [1:0] RD_WAIT = 2'd2;
   localparam logic [1:0] WR_REQ  = 2'd3;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   logic [1:0]      state;
   logic [TO_W-1:0] to_cnt;
   logic            any_strobe;
   logic            to_hit;
   logic            unused_jdo;

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign to_hit     = (to_cnt == TO_LIMIT);
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         to_cnt        <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
         mon_address   <= '0;
         mon_read      <= 1'b0;
         mon_write     <= 1'b0;
         mon_writedata <= '0;
      end else if (state == IDLE) begin
         // Priority a > b > no_action_a; losers are dropped without error.
         if (take_action_ocimem_a) begin
            mon_address   <= jdo[17+ADDR_W-1:17];
            monitor_error <= 1'b0;
            if (jdo[34]) begin
               mon_read      <= 1'b1;
               monitor_ready <= 1'b0;
               to_cnt        <= '0;
               state         <= RD_REQ;
            end
         end else if (take_action_ocimem_b) begin
            mon_writedata <= jdo[34:3];
            mon_write     <= 1'b1;
            monitor_ready <= 1'b0;
            to_cnt        <= '0;
            state         <= WR_REQ;
         end else if (take_no_action_ocimem_a) begin
            mon_read      <= 1'b1;
            monitor_ready <= 1'b0;
            to_cnt        <= '0;
            state         <= RD_REQ;
         end
      end else begin
         if (any_strobe)
            monitor_error <= 1'b1;
         // Saturates so an accept on the last allowed cycle still times out in RD_WAIT.
         if (!to_hit)
            to_cnt <= to_cnt + 1'b1;
         case (state)
            RD_REQ: begin
               if (!mon_waitrequest) begin
                  mon_read <= 1'b0;
                  state    <= RD_WAIT;
               end else if (to_hit) begin
                  mon_read      <= 1'b0;
                  monitor_error <= 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            RD_WAIT: begin
               if (mon_readdatavalid) begin
                  MonDReg       <= mon_readdata;
                  mon_address   <= mon_address + 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= IDLE;
               end else if (to_hit) begin
                  monitor_error <= 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               if (!mon_waitrequest) begin
                  mon_write     <= 1'b0;
                  mon_address   <= mon_address + 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= IDLE;
               end else if (to_hit) begin
                  mon_write     <= 1'b0;
                  monitor_error <= 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_ocimem_sequencer.sv
// Directed bench for jtag_ocimem_sequencer; the bench plays the Avalon slave.
module tb_jtag_ocimem_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  mon_address;
   logic        mon_read, mon_write;
   logic [31:0] mon_writedata, mon_readdata;
   logic        mon_readdatavalid, mon_waitrequest;

   int total = 0;
   int bad   = 0;
   int rd_cycles;

   always #5 clk = ~clk;

   jtag_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(255), .TO_W(8)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .mon_address(mon_address), .mon_read(mon_read), .mon_write(mon_write),
      .mon_writedata(mon_writedata), .mon_readdata(mon_readdata),
      .mon_readdatavalid(mon_readdatavalid), .mon_waitrequest(mon_waitrequest)
   );

   function automatic logic [37:0] mk_addr(input logic [7:0] a, input logic rd);
      return {3'b000, rd, 9'd0, a, 17'd0};
   endfunction

   function automatic logic [37:0] mk_data(input logic [31:0] d);
      return {3'b000, d, 3'b000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic strobes_off();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   initial begin
      reset = 1'b1; jdo = '0; strobes_off();
      mon_readdata = '0; mon_readdatavalid = 1'b0; mon_waitrequest = 1'b0;
      step(); step();
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_ready", monitor_ready, 1);
      chk("rst_error", monitor_error, 0);
      chk("rst_addr", mon_address, 8'h00);
      chk("rst_rdwr", {mon_read, mon_write}, 0);
      chk("rst_wdata", mon_writedata, 32'h0);
      reset = 1'b0;
      step();

      // 1: address load with auto-read, best-case slave
      jdo = mk_addr(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
      step(); strobes_off();
      chk("t1_read_hi", mon_read, 1);
      chk("t1_addr", mon_address, 8'h10);
      chk("t1_busy", monitor_ready, 0);
      step();
      chk("t1_read_lo", mon_read, 0);
      mon_readdata = 32'hDEADBEEF; mon_readdatavalid = 1'b1;
      step(); mon_readdatavalid = 1'b0; mon_readdata = '0;
      chk("t1_mondreg", MonDReg, 32'hDEADBEEF);
      chk("t1_ready", monitor_ready, 1);
      chk("t1_addr_inc", mon_address, 8'h11);

      // 2: write at 0xFF with 3 stall cycles, address wraps
      jdo = mk_addr(8'hFF, 1'b0); take_action_ocimem_a = 1'b1;
      step(); strobes_off();
      chk("t2_noread", mon_read, 0);
      chk("t2_ready_kept", monitor_ready, 1);
      chk("t2_addr", mon_address, 8'hFF);
      jdo = mk_data(32'h12345678); take_action_ocimem_b = 1'b1; mon_waitrequest = 1'b1;
      step(); strobes_off();
      for (int i = 0; i < 3; i++) begin
         chk("t2_write_held", mon_write, 1);
         chk("t2_wdata", mon_writedata, 32'h12345678);
         chk("t2_addr_held", mon_address, 8'hFF);
         if (i < 2) step();
      end
      mon_waitrequest = 1'b0;
      step();
      chk("t2_write_lo", mon_write, 0);
      chk("t2_ready", monitor_ready, 1);
      chk("t2_wrap", mon_address, 8'h00);

      // 3: read stuck in waitrequest; counter runs 0..TIMEOUT, so read is high 256 cycles
      take_no_action_ocimem_a = 1'b1; mon_waitrequest = 1'b1;
      step(); strobes_off();
      rd_cycles = 0;
      for (int i = 0; i < 300 && mon_read; i++) begin
         rd_cycles++;
         step();
      end
      chk("t3_read_cycles", rd_cycles, 256);
      chk("t3_read_lo", mon_read, 0);
      chk("t3_error", monitor_error, 1);
      chk("t3_ready", monitor_ready, 1);
      chk("t3_addr", mon_address, 8'h00);
      chk("t3_mondreg", MonDReg, 32'hDEADBEEF);
      mon_waitrequest = 1'b0;
      jdo = mk_addr(8'h20, 1'b0); take_action_ocimem_a = 1'b1;
      step(); strobes_off();
      chk("t3_err_clr", monitor_error, 0);
      chk("t3_addr_ld", mon_address, 8'h20);

      // 4: overrun write strobe during RD_WAIT
      take_no_action_ocimem_a = 1'b1;
      step(); strobes_off();
      chk("t4_read_hi", mon_read, 1);
      step();
      jdo = mk_data(32'hCAFEF00D); take_action_ocimem_b = 1'b1;
      step(); strobes_off();
      chk("t4_overrun", monitor_error, 1);
      chk("t4_wdata", mon_writedata, 32'h12345678);
      chk("t4_nowrite", mon_write, 0);
      chk("t4_busy", monitor_ready, 0);
      mon_readdata = 32'h0BADF00D; mon_readdatavalid = 1'b1;
      step(); mon_readdatavalid = 1'b0; mon_readdata = '0;
      chk("t4_mondreg", MonDReg, 32'h0BADF00D);
      chk("t4_ready", monitor_ready, 1);
      chk("t4_addr", mon_address, 8'h21);
      chk("t4_err_sticky", monitor_error, 1);

      // 5: a and b together, a wins and b is dropped silently
      jdo = mk_addr(8'h40, 1'b0); take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
      step(); strobes_off();
      chk("t5_addr", mon_address, 8'h40);
      chk("t5_error", monitor_error, 0);
      chk("t5_nowrite", mon_write, 0);
      chk("t5_ready", monitor_ready, 1);
      step();
      chk("t5_nowrite2", mon_write, 0);
      chk("t5_wdata", mon_writedata, 32'h12345678);

      // 6: reset right after read accept, late readdatavalid ignored
      take_no_action_ocimem_a = 1'b1;
      step(); strobes_off();
      chk("t6_read_hi", mon_read, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_rst_addr", mon_address, 8'h00);
      chk("t6_rst_mondreg", MonDReg, 32'h0);
      step();
      mon_readdata = 32'h55AA55AA; mon_readdatavalid = 1'b1;
      step(); mon_readdatavalid = 1'b0; mon_readdata = '0;
      chk("t6_mondreg", MonDReg, 32'h0);
      chk("t6_ready", monitor_ready, 1);
      chk("t6_error", monitor_error, 0);
      chk("t6_addr", mon_address, 8'h00);
      chk("t6_rdwr", {mon_read, mon_write}, 0);
      chk("t6_wdata", mon_writedata, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
